// File: rtl/otp_session_ctrl_pkg.sv
// Shared definitions for the OTP session controller: state codes and
// default parameter values used by the RTL and the testbench.
package otp_session_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_LATCH = 3'd2,
        ST_SHOW  = 3'd3,
        ST_GRANT = 3'd4,
        ST_LOCK  = 3'd5
    } state_t;

    localparam int OTP_W_DEF        = 8;
    localparam int MAX_FAIL_DEF     = 3;
    localparam int EXPIRE_TICKS_DEF = 30;
    localparam int GRANT_TICKS_DEF  = 5;
    localparam int LOCK_TICKS_DEF   = 10;
    localparam int TCW_DEF          = 6;

    // States whose dwell time is measured in slow-divider ticks.
    function automatic logic is_timed(input state_t s);
        return (s == ST_SHOW) || (s == ST_GRANT) || (s == ST_LOCK);
    endfunction

endpackage

// File: rtl/otp_session_ctrl_timer.sv
// Tick counter for the session controller: clear, tick enable, saturating
// count, and a done strobe on the tick that reaches the terminal value.
module session_timer #(
    parameter int TCW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic [TCW-1:0] term,
    output logic           done
);

    localparam logic [TCW-1:0] ONE   = TCW'(1);
    localparam logic [TCW-1:0] SAT_V = {TCW{1'b1}};

    logic [TCW-1:0] count_q, count_d;

    // NOTE: every variable written here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != SAT_V)) begin
            count_d = count_q + ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = en && (count_q == (term - ONE));

endmodule

// File: rtl/otp_session_ctrl.sv
// Session controller: issues one OTP per session from the LFSR, checks the
// entered code, and enforces expiry, failed-attempt counting and lockout.
module otp_session_ctrl
    import otp_session_ctrl_pkg::*;
#(
    parameter int OTP_W        = OTP_W_DEF,
    parameter int MAX_FAIL     = MAX_FAIL_DEF,
    parameter int EXPIRE_TICKS = EXPIRE_TICKS_DEF,
    parameter int GRANT_TICKS  = GRANT_TICKS_DEF,
    parameter int LOCK_TICKS   = LOCK_TICKS_DEF,
    parameter int TCW          = TCW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gen_req,
    input  logic             submit,
    input  logic [OTP_W-1:0] code_in,
    input  logic [OTP_W-1:0] lfsr_q,
    output logic             lfsr_step,
    output logic [OTP_W-1:0] otp_out,
    output logic             disp_en,
    output logic             grant,
    output logic             fail,
    output logic             locked,
    output logic [1:0]       fail_cnt,
    output logic [2:0]       state_o
);

    localparam logic [TCW-1:0] EXPIRE_T = TCW'(EXPIRE_TICKS);
    localparam logic [TCW-1:0] GRANT_T  = TCW'(GRANT_TICKS);
    localparam logic [TCW-1:0] LOCK_T   = TCW'(LOCK_TICKS);
    localparam logic [1:0]     MAX_F    = 2'(MAX_FAIL);

    state_t           state_q, state_d;
    logic [OTP_W-1:0] otp_q, otp_d;
    logic [1:0]       fail_cnt_q, fail_cnt_d;
    logic             fail_q, fail_d;

    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_done;
    logic [TCW-1:0]   tmr_term;

    // Timer inputs depend only on registered state, keeping done out of any comb loop.
    assign tmr_en = tick && is_timed(state_q);

    always_comb begin
        tmr_term = EXPIRE_T;
        case (state_q)
            ST_GRANT: tmr_term = GRANT_T;
            ST_LOCK:  tmr_term = LOCK_T;
            default:  tmr_term = EXPIRE_T;
        endcase
    end

    session_timer #(.TCW(TCW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .done  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        otp_d      = otp_q;
        fail_cnt_d = fail_cnt_q;
        fail_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gen_req) state_d = ST_GEN;
            end
            ST_GEN: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                otp_d   = lfsr_q;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                // A submit takes priority over an expiry tick in the same cycle.
                if (submit) begin
                    if (code_in == otp_q) begin
                        state_d    = ST_GRANT;
                        fail_cnt_d = 2'd0;
                    end else begin
                        fail_d     = 1'b1;
                        fail_cnt_d = fail_cnt_q + 2'd1;
                        if ((fail_cnt_q + 2'd1) == MAX_F) state_d = ST_LOCK;
                    end
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                    otp_d   = '0;
                end
            end
            ST_GRANT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    otp_d   = '0;
                end
            end
            ST_LOCK: begin
                if (tmr_done) begin
                    state_d    = ST_IDLE;
                    otp_d      = '0;
                    fail_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    // NOTE: asynchronous reset clears every register immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            otp_q      <= '0;
            fail_cnt_q <= 2'd0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            otp_q      <= otp_d;
            fail_cnt_q <= fail_cnt_d;
            fail_q     <= fail_d;
        end
    end

    assign lfsr_step = (state_q == ST_GEN);
    assign disp_en   = (state_q == ST_SHOW);
    assign grant     = (state_q == ST_GRANT);
    assign locked    = (state_q == ST_LOCK);
    assign otp_out   = otp_q;
    assign fail      = fail_q;
    assign fail_cnt  = fail_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Self-checking bench for otp_session_ctrl: directed scenarios followed by
// randomized stimulus, compared each cycle against a countdown-based model.
module tb_otp_session_ctrl;
    import otp_session_ctrl_pkg::*;

    localparam int W = OTP_W_DEF;

    // Spec-defined state codes as the bench sees them.
    localparam int M_IDLE = 0, M_GEN = 1, M_LATCH = 2, M_SHOW = 3, M_GRANT = 4, M_LOCK = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick, gen_req, submit;
    logic [W-1:0] code_in, lfsr_q;
    logic         lfsr_step, disp_en, grant, fail, locked;
    logic [W-1:0] otp_out;
    logic [1:0]   fail_cnt;
    logic [2:0]   state_o;

    logic [W-1:0] next_lfsr;
    logic [W-1:0] lfsr_reg;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, held OTP, consecutive fails, ticks left in the current timed state.
    int m_state, m_otp, m_fails, m_rem, m_fail, m_lfsr;

    always #5 clk = ~clk;

    otp_session_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .gen_req   (gen_req),
        .submit    (submit),
        .code_in   (code_in),
        .lfsr_q    (lfsr_q),
        .lfsr_step (lfsr_step),
        .otp_out   (otp_out),
        .disp_en   (disp_en),
        .grant     (grant),
        .fail      (fail),
        .locked    (locked),
        .fail_cnt  (fail_cnt),
        .state_o   (state_o)
    );

    // Stand-in LFSR: each step request loads the value the bench queued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_reg <= '0;
        else if (lfsr_step) lfsr_reg <= next_lfsr;
    end
    assign lfsr_q = lfsr_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_otp   = 0;
        m_fails = 0;
        m_rem   = 0;
        m_fail  = 0;
        m_lfsr  = 0;
    endtask

    task automatic model_update(input bit g, input bit s, input int c, input bit t);
        m_fail = 0;
        case (m_state)
            M_IDLE:  if (g) m_state = M_GEN;
            M_GEN: begin
                m_lfsr  = int'(next_lfsr);
                m_state = M_LATCH;
            end
            M_LATCH: begin
                m_otp   = m_lfsr;
                m_state = M_SHOW;
                m_rem   = EXPIRE_TICKS_DEF;
            end
            M_SHOW: begin
                if (s && c == m_otp) begin
                    m_state = M_GRANT;
                    m_fails = 0;
                    m_rem   = GRANT_TICKS_DEF;
                end else if (s) begin
                    m_fail  = 1;
                    m_fails = m_fails + 1;
                    if (m_fails == MAX_FAIL_DEF) begin
                        m_state = M_LOCK;
                        m_rem   = LOCK_TICKS_DEF;
                    end else if (t) begin
                        m_rem = m_rem - 1;
                    end
                end else if (t) begin
                    if (m_rem == 1) begin
                        m_state = M_IDLE;
                        m_otp   = 0;
                    end else begin
                        m_rem = m_rem - 1;
                    end
                end
            end
            M_GRANT: if (t) begin
                if (m_rem == 1) begin
                    m_state = M_IDLE;
                    m_otp   = 0;
                end else m_rem = m_rem - 1;
            end
            M_LOCK: if (t) begin
                if (m_rem == 1) begin
                    m_state = M_IDLE;
                    m_otp   = 0;
                    m_fails = 0;
                end else m_rem = m_rem - 1;
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"},     32'(state_o),   32'(m_state));
        check({tag, ".otp"},       32'(otp_out),   32'(m_otp));
        check({tag, ".fail_cnt"},  32'(fail_cnt),  32'(m_fails));
        check({tag, ".fail"},      32'(fail),      32'(m_fail));
        check({tag, ".lfsr_step"}, 32'(lfsr_step), 32'(m_state == M_GEN));
        check({tag, ".disp_en"},   32'(disp_en),   32'(m_state == M_SHOW));
        check({tag, ".grant"},     32'(grant),     32'(m_state == M_GRANT));
        check({tag, ".locked"},    32'(locked),    32'(m_state == M_LOCK));
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge.
    task automatic step(input string tag, input bit g, input bit s, input logic [W-1:0] c, input bit t);
        gen_req = g;
        submit  = s;
        code_in = c;
        tick    = t;
        model_update(g, s, int'(c), t);
        @(posedge clk);
        @(negedge clk);
        gen_req = 1'b0;
        submit  = 1'b0;
        tick    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, 1'b0, '0, 1'b1);
            step(tag, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic start_session(input string tag, input logic [W-1:0] v);
        next_lfsr = v;
        step(tag, 1'b1, 1'b0, '0, 1'b0);
        step(tag, 1'b0, 1'b0, '0, 1'b0);
        step(tag, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".state"},   32'(state_o),  32'd0);
        check({tag, ".otp"},     32'(otp_out),  32'd0);
        check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'd0);
        check({tag, ".outs"},
              32'({lfsr_step, disp_en, grant, fail, locked}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs({tag, ".after"});
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        gen_req   = 1'b0;
        submit    = 1'b0;
        code_in   = '0;
        next_lfsr = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Generation latency and latch of the post-step LFSR value.
        next_lfsr = 8'hA5;
        step("t1_gen", 1'b1, 1'b0, '0, 1'b0);
        check("t1_step_hi", 32'(lfsr_step), 32'd1);
        step("t1_latch", 1'b0, 1'b0, '0, 1'b0);
        check("t1_step_lo", 32'(lfsr_step), 32'd0);
        step("t1_show", 1'b0, 1'b0, '0, 1'b0);
        check("t1_otp", 32'(otp_out), 32'hA5);
        check("t1_disp", 32'(disp_en), 32'd1);

        // Correct code, grant held for GRANT_TICKS ticks.
        step("t2_sub", 1'b0, 1'b1, 8'hA5, 1'b0);
        check("t2_grant", 32'(grant), 32'd1);
        ticks("t2_hold", GRANT_TICKS_DEF - 1);
        check("t2_still", 32'(grant), 32'd1);
        ticks("t2_end", 1);
        check("t2_idle", 32'({state_o, otp_out, fail_cnt, disp_en}), 32'd0);

        // Two mismatches then a match.
        start_session("t3_start", 8'hA5);
        step("t3_m1", 1'b0, 1'b1, 8'h00, 1'b0);
        check("t3_cnt1", 32'(fail_cnt), 32'd1);
        step("t3_gap1", 1'b0, 1'b0, '0, 1'b0);
        step("t3_m2", 1'b0, 1'b1, 8'h11, 1'b0);
        check("t3_cnt2", 32'(fail_cnt), 32'd2);
        step("t3_gap2", 1'b0, 1'b0, '0, 1'b0);
        step("t3_ok", 1'b0, 1'b1, 8'hA5, 1'b0);
        check("t3_grant", 32'({grant, fail_cnt}), 32'h4);
        ticks("t3_end", GRANT_TICKS_DEF);

        // Lockout, with ignored inputs while locked.
        start_session("t4_start", 8'h3C);
        for (int i = 0; i < MAX_FAIL_DEF; i++) step("t4_miss", 1'b0, 1'b1, 8'h3D, 1'b0);
        check("t4_locked", 32'({locked, fail_cnt}), 32'h7);
        step("t4_sub", 1'b0, 1'b1, 8'h3C, 1'b0);
        step("t4_gen", 1'b1, 1'b0, '0, 1'b0);
        ticks("t4_wait", LOCK_TICKS_DEF);
        check("t4_unlock", 32'({locked, fail_cnt, state_o}), 32'd0);

        // Expiry, then a submit coinciding with the expiring tick.
        start_session("t5_start", 8'h5A);
        ticks("t5_exp", EXPIRE_TICKS_DEF);
        check("t5_idle", 32'({state_o, otp_out}), 32'd0);
        start_session("t5b_start", 8'h77);
        ticks("t5b_wait", EXPIRE_TICKS_DEF - 1);
        step("t5b_race", 1'b0, 1'b1, 8'h77, 1'b1);
        check("t5b_grant", 32'(grant), 32'd1);
        ticks("t5b_end", GRANT_TICKS_DEF);

        // Asynchronous reset between edges, mid-SHOW and mid-LOCK.
        start_session("t6_show", 8'h99);
        step("t6_miss", 1'b0, 1'b1, 8'h98, 1'b0);
        mid_cycle_reset("t6_rst_show");
        start_session("t6_lock", 8'h42);
        for (int i = 0; i < MAX_FAIL_DEF; i++) step("t6_miss", 1'b0, 1'b1, 8'h43, 1'b0);
        ticks("t6_lockwait", 3);
        mid_cycle_reset("t6_rst_lock");

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            bit          g, s, t;
            logic [W-1:0] c;
            if (m_state == M_IDLE) next_lfsr = W'($urandom);
            g = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 2) == 0) ? W'(m_otp) : W'($urandom);
            step("rand", g, s, c, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
